// File: rtl/can_bitmonitor.sv
// Per-bit CAN transmit/receive comparator with frame-aware error classification,
// per-frame status and a saturating error-event counter.
module can_bitmonitor #(
   parameter int CNT_WIDTH = 8,
   parameter int POS_WIDTH = 7
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 activ,
   input  logic                 bitin,
   input  logic                 bitout,
   input  logic [1:0]           mode,
   input  logic                 frame_start,
   input  logic                 frame_end,
   input  logic                 clr_cnt,
   output logic                 biterror,
   output logic                 err_sticky,
   output logic                 arblost,
   output logic                 first_valid,
   output logic [POS_WIDTH-1:0] first_pos,
   output logic [POS_WIDTH-1:0] bitpos,
   output logic [CNT_WIDTH-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, MON, LOST} state_t;

   localparam logic [POS_WIDTH-1:0] POS_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               r_state;
   logic                 r_biterror, r_sticky, r_arblost, r_first_valid;
   logic [POS_WIDTH-1:0] r_first_pos, r_bitpos;
   logic [CNT_WIDTH-1:0] r_cnt;

   logic w_eval, w_rec_dom, w_arb, w_err;

   // Frame boundaries take precedence over a coincident strobe.
   always_comb begin
      w_eval    = activ && (r_state == MON) && !frame_start && !frame_end;
      w_rec_dom = bitout && !bitin;
      w_arb     = (mode == 2'b01) && w_rec_dom;
      w_err     = (bitin != bitout) && !(((mode == 2'b01) || (mode == 2'b10)) && w_rec_dom);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_biterror    <= 1'b0;
         r_sticky      <= 1'b0;
         r_arblost     <= 1'b0;
         r_first_valid <= 1'b0;
         r_first_pos   <= '0;
         r_bitpos      <= '0;
         r_cnt         <= '0;
      end else begin
         if (clr_cnt)
            r_cnt <= '0;
         else if (w_eval && w_err && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + 1'b1;

         if (frame_start) begin
            r_state       <= MON;
            r_biterror    <= 1'b0;
            r_sticky      <= 1'b0;
            r_arblost     <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_pos   <= '0;
            r_bitpos      <= '0;
         end else if (frame_end && (r_state != IDLE)) begin
            r_state <= IDLE;
         end else if (w_eval) begin
            r_biterror <= w_err;
            if (r_bitpos != POS_MAX)
               r_bitpos <= r_bitpos + 1'b1;
            if (w_arb) begin
               r_arblost <= 1'b1;
               r_state   <= LOST;
            end
            if (w_err) begin
               r_sticky <= 1'b1;
               if (!r_first_valid) begin
                  r_first_valid <= 1'b1;
                  r_first_pos   <= r_bitpos;
               end
            end
         end
      end
   end

   assign biterror    = r_biterror;
   assign err_sticky  = r_sticky;
   assign arblost     = r_arblost;
   assign first_valid = r_first_valid;
   assign first_pos   = r_first_pos;
   assign bitpos      = r_bitpos;
   assign err_count   = r_cnt;

endmodule

// File: tb/tb_can_bitmonitor.sv
// Scoreboard bench for can_bitmonitor: directed scenarios plus random traffic,
// checked against a queue-based frame model.
module tb_can_bitmonitor;

   localparam int CW = 3;
   localparam int PW = 5;
   localparam int CMAX = (1 << CW) - 1;
   localparam int PMAX = (1 << PW) - 1;

   typedef struct packed {
      logic          biterror;
      logic          err_sticky;
      logic          arblost;
      logic          first_valid;
      logic [PW-1:0] first_pos;
      logic [PW-1:0] bitpos;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clock = 0, reset = 0, activ = 0, bitin = 0, bitout = 0;
   logic frame_start = 0, frame_end = 0, clr_cnt = 0;
   logic [1:0] mode = 0;
   logic biterror, err_sticky, arblost, first_valid;
   logic [PW-1:0] first_pos, bitpos;
   logic [CW-1:0] err_count;

   can_bitmonitor #(.CNT_WIDTH(CW), .POS_WIDTH(PW)) dut (
      .clock(clock), .reset(reset), .activ(activ), .bitin(bitin), .bitout(bitout),
      .mode(mode), .frame_start(frame_start), .frame_end(frame_end), .clr_cnt(clr_cnt),
      .biterror(biterror), .err_sticky(err_sticky), .arblost(arblost),
      .first_valid(first_valid), .first_pos(first_pos), .bitpos(bitpos),
      .err_count(err_count)
   );

   always #5 clock = ~clock;

   int n_tests = 0, n_fail = 0;
   exp_t exp_q[$];

   // Reference model: frame open/lost flags, list of error positions in the frame.
   bit m_open, m_lost, m_biterr, m_arb;
   int m_bitpos, m_cnt;
   int m_errs[$];

   function automatic void model_reset();
      m_open = 0; m_lost = 0; m_biterr = 0; m_arb = 0;
      m_bitpos = 0; m_cnt = 0; m_errs.delete();
   endfunction

   function automatic void model_step(bit fs, bit fe, bit act, bit bi, bit bo, bit [1:0] md, bit clr);
      bit err;
      if (fs) begin
         m_open = 1; m_lost = 0; m_biterr = 0; m_arb = 0; m_bitpos = 0; m_errs.delete();
      end else if (fe && m_open) begin
         m_open = 0;
      end else if (act && m_open && !m_lost) begin
         err = (bi != bo);
         if (md == 2'b01 && bo && !bi) begin
            m_lost = 1; m_arb = 1; err = 0;
         end
         if (md == 2'b10 && bo && !bi) err = 0;
         if (err) begin
            m_errs.push_back(m_bitpos);
            if (m_cnt < CMAX) m_cnt++;
         end
         m_biterr = err;
         if (m_bitpos < PMAX) m_bitpos++;
      end
      if (clr) m_cnt = 0;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.biterror    = m_biterr;
      e.err_sticky  = (m_errs.size() > 0);
      e.arblost     = m_arb;
      e.first_valid = (m_errs.size() > 0);
      e.first_pos   = (m_errs.size() > 0) ? PW'(m_errs[0]) : '0;
      e.bitpos      = PW'(m_bitpos);
      e.cnt         = CW'(m_cnt);
      return e;
   endfunction

   function automatic exp_t dut_out();
      exp_t a;
      a = {biterror, err_sticky, arblost, first_valid, first_pos, bitpos, err_count};
      return a;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got be=%0b st=%0b arb=%0b fv=%0b fp=%0d pos=%0d cnt=%0d, want be=%0b st=%0b arb=%0b fv=%0b fp=%0d pos=%0d cnt=%0d",
                  name, act.biterror, act.err_sticky, act.arblost, act.first_valid, act.first_pos, act.bitpos, act.cnt,
                  exp.biterror, exp.err_sticky, exp.arblost, exp.first_valid, exp.first_pos, exp.bitpos, exp.cnt);
      end
   endtask

   // Monitor: one expectation per clock edge, compared half a cycle later.
   always @(negedge clock) begin
      if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
   end

   task automatic step(input bit fs, input bit fe, input bit act, input bit bi, input bit bo,
                       input bit [1:0] md, input bit clr);
      frame_start = fs; frame_end = fe; activ = act; bitin = bi; bitout = bo; mode = md; clr_cnt = clr;
      @(posedge clock);
      model_step(fs, fe, act, bi, bo, md, clr);
      exp_q.push_back(model_out());
      #1;
      frame_start = 0; frame_end = 0; activ = 0; clr_cnt = 0;
   endtask

   task automatic strobe(input bit bi, input bit bo, input bit [1:0] md);
      step(0, 0, 1, bi, bo, md, 0);
   endtask

   initial begin
      bit b;
      model_reset();
      reset = 1;
      #3 check("reset_state", dut_out(), model_out());
      @(negedge clock); reset = 0;
      @(posedge clock); #1;

      // Clean frame, mode 00
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin b = 1'($urandom); strobe(b, b, 2'b00); end
      step(0, 1, 0, 0, 0, 0, 0);

      // Errors at positions 3 and 7
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         b = 1'($urandom);
         strobe((i == 3 || i == 7) ? ~b : b, b, 2'b00);
      end

      // Arbitration loss on the fifth strobe, later mismatches ignored
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) strobe(0, 1, 2'b01);
         else if (i > 4) strobe(1, 0, 2'($urandom_range(0, 3)));
         else strobe(1, 1, 2'b01);
      end
      step(1, 0, 0, 0, 0, 0, 0);

      // Recessive-tolerant slot
      strobe(0, 1, 2'b10);
      strobe(1, 0, 2'b10);
      strobe(1, 1, 2'b10);
      strobe(0, 1, 2'b11);

      // Counter saturation, then clear colliding with an error strobe
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) strobe(1, 0, 2'b00);
      step(0, 0, 1, 1, 0, 2'b00, 1);
      strobe(0, 1, 2'b00);

      // Bit position saturation
      for (int i = 0; i < PMAX + 4; i++) strobe(1, 1, 2'b00);

      // Async reset mid-frame with err_sticky set
      step(1, 0, 0, 0, 0, 0, 0);
      strobe(1, 0, 2'b00);
      @(negedge clock); #2;
      reset = 1;
      model_reset();
      #1 check("async_reset", dut_out(), model_out());
      @(posedge clock); #1 reset = 0;
      for (int i = 0; i < 3; i++) strobe(1, 0, 2'b00);
      step(1, 1, 1, 1, 0, 2'b00, 0);
      strobe(1, 0, 2'b00);

      // Random traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 60),
              1'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 99) < 3));

      repeat (3) @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
